// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end: FSM state encoding,
// command-byte layout and a small elaboration-time helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RD_REQ  = 3'd2,
    RD_LOAD = 3'd3,
    RD_DATA = 3'd4,
    WR_DATA = 3'd5,
    DONE    = 3'd6
  } spi_state_e;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_W      = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// Register-block request bus driven by the SPI slave: one-cycle strobe with
// address/data, plus read data returned one clock after a read strobe.
interface spi_slave_if_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              rw;
  logic              valid;
  logic [ADDR_W-1:0] addr_to_reg;
  logic [DATA_W-1:0] data_to_reg;
  logic [DATA_W-1:0] data_in_reg;

  modport master (output rw, valid, addr_to_reg, data_to_reg, input data_in_reg);
  modport slave  (input rw, valid, addr_to_reg, data_to_reg, output data_in_reg);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer with one-clock rise/fall pulses derived from the
// synchronized level; RESET_VAL sets the idle level seen straight out of reset.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level_s,
  output logic rise_s,
  output logic fall_s
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level_s = sync_r[STAGES-1];
  assign rise_s  = level_s & ~prev_r;
  assign fall_s  = ~level_s & prev_r;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end issuing register-bus read/write strobes.
// Optional feature: define SPI_BURST_EN for multi-byte bursts with address post-increment.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spi_sclk,
  input  logic           spi_cs_n,
  input  logic           spi_mosi,
  output logic           spi_miso,
  output logic           spi_miso_oe,
  spi_slave_if_if.master bus
);

  localparam int SR_W  = max_int(CMD_W, DATA_W);
  localparam int CNT_W = $clog2(SR_W) + 1;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_unused_s;
  logic mosi_lvl_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk),
    .level_s(sclk_lvl_unused_s), .rise_s(sclk_rise_s), .fall_s(sclk_fall_s));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .level_s(cs_lvl_s), .rise_s(cs_rise_s), .fall_s(cs_fall_unused_s));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level_s(mosi_lvl_s), .rise_s(mosi_rise_unused_s), .fall_s(mosi_fall_unused_s));

  spi_state_e        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [SR_W-2:0]   rx_sr_r, rx_nxt_s, rx_shift_s;
  logic [DATA_W-1:0] tx_sr_r, tx_nxt_s, rx_byte_s;
  logic              rise_seen_r, rise_seen_nxt_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nxt_s, ptr_inc_s, cmd_addr_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] data_r, data_nxt_s;
  logic              rw_r, rw_nxt_s, valid_r, valid_nxt_s, oe_r, oe_nxt_s;

  // Frame decoder: next state and next value of every register
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    rx_nxt_s        = rx_sr_r;
    tx_nxt_s        = tx_sr_r;
    rise_seen_nxt_s = rise_seen_r;
    ptr_nxt_s       = ptr_r;
    addr_nxt_s      = addr_r;
    data_nxt_s      = data_r;
    rw_nxt_s        = rw_r;
    valid_nxt_s     = 1'b0;
    oe_nxt_s        = oe_r;
    rx_shift_s      = {rx_sr_r[SR_W-3:0], mosi_lvl_s};
    rx_byte_s       = {rx_sr_r[DATA_W-2:0], mosi_lvl_s};
    cmd_addr_s      = {rx_sr_r[ADDR_W-2:0], mosi_lvl_s};
    cnt_inc_s       = cnt_r + CNT_ONE;
    ptr_inc_s       = ptr_r + ADDR_ONE;
    if (cs_rise_s) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
      tx_nxt_s    = DATA_ZERO;
      oe_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          if (!cs_lvl_s) state_nxt_s = CMD;
          else           state_nxt_s = IDLE;
        end
        CMD: begin
          if (sclk_rise_s) begin
            rx_nxt_s  = rx_shift_s;
            cnt_nxt_s = cnt_inc_s;
            if (cnt_r == CMD_LAST) begin
              cnt_nxt_s = CNT_ZERO;
              ptr_nxt_s = cmd_addr_s;
              if (rx_sr_r[CMD_RW_BIT-1]) begin
                state_nxt_s = WR_DATA;
              end else begin
                state_nxt_s = RD_REQ;
                valid_nxt_s = 1'b1;
                rw_nxt_s    = 1'b0;
                addr_nxt_s  = cmd_addr_s;
              end
            end else begin
              state_nxt_s = CMD;
            end
          end else begin
            state_nxt_s = CMD;
          end
        end
        RD_REQ:  state_nxt_s = RD_LOAD;
        RD_LOAD: begin
          tx_nxt_s        = bus.data_in_reg;
          oe_nxt_s        = 1'b1;
          cnt_nxt_s       = CNT_ZERO;
          rise_seen_nxt_s = 1'b0;
          state_nxt_s     = RD_DATA;
        end
        RD_DATA: begin
          // a fall only counts once a rise has been seen here, so the fall
          // trailing the previous byte's last rise never shifts tx_sr
          if (sclk_rise_s) begin
            rise_seen_nxt_s = 1'b1;
            cnt_nxt_s       = cnt_inc_s;
            if (cnt_r == DATA_LAST) begin
`ifdef SPI_BURST_EN
              ptr_nxt_s   = ptr_inc_s;
              addr_nxt_s  = ptr_inc_s;
              valid_nxt_s = 1'b1;
              rw_nxt_s    = 1'b0;
              state_nxt_s = RD_REQ;
`else
              tx_nxt_s    = DATA_ZERO;
              oe_nxt_s    = 1'b0;
              state_nxt_s = DONE;
`endif
            end else begin
              state_nxt_s = RD_DATA;
            end
          end else if (sclk_fall_s && rise_seen_r) begin
            tx_nxt_s = {tx_sr_r[DATA_W-2:0], 1'b0};
          end else begin
            state_nxt_s = RD_DATA;
          end
        end
        WR_DATA: begin
          if (sclk_rise_s) begin
            rx_nxt_s  = rx_shift_s;
            cnt_nxt_s = cnt_inc_s;
            if (cnt_r == DATA_LAST) begin
              valid_nxt_s = 1'b1;
              rw_nxt_s    = 1'b1;
              addr_nxt_s  = ptr_r;
              data_nxt_s  = rx_byte_s;
              cnt_nxt_s   = CNT_ZERO;
`ifdef SPI_BURST_EN
              ptr_nxt_s   = ptr_inc_s;
              state_nxt_s = WR_DATA;
`else
              state_nxt_s = DONE;
`endif
            end else begin
              state_nxt_s = WR_DATA;
            end
          end else begin
            state_nxt_s = WR_DATA;
          end
        end
        DONE: begin
          tx_nxt_s = DATA_ZERO;
          oe_nxt_s = 1'b0;
          if (cs_lvl_s) state_nxt_s = IDLE;
          else          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = IDLE;
          tx_nxt_s    = DATA_ZERO;
          oe_nxt_s    = 1'b0;
        end
      endcase
    end
  end

  // State, shifters and registered bus/pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      rx_sr_r     <= {(SR_W-1){1'b0}};
      tx_sr_r     <= DATA_ZERO;
      rise_seen_r <= 1'b0;
      ptr_r       <= {ADDR_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= DATA_ZERO;
      rw_r        <= 1'b0;
      valid_r     <= 1'b0;
      oe_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rx_sr_r     <= rx_nxt_s;
      tx_sr_r     <= tx_nxt_s;
      rise_seen_r <= rise_seen_nxt_s;
      ptr_r       <= ptr_nxt_s;
      addr_r      <= addr_nxt_s;
      data_r      <= data_nxt_s;
      rw_r        <= rw_nxt_s;
      valid_r     <= valid_nxt_s;
      oe_r        <= oe_nxt_s;
    end
  end

  assign spi_miso        = tx_sr_r[DATA_W-1];
  assign spi_miso_oe     = oe_r;
  assign bus.rw          = rw_r;
  assign bus.valid       = valid_r;
  assign bus.addr_to_reg = addr_r;
  assign bus.data_to_reg = data_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a bit-banged SPI master, a register-block
// read model, and a scoreboard of expected bus strobes.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n, spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rise8_cyc = 0;
  logic [7:0]  mem [16];
  logic [12:0] exp_q [$];
  logic [12:0] obs_q [$];
  int          obs_cyc_q [$];
  logic [23:0] miso_v, oe_v;

  spi_slave_if_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

  spi_slave_if #(.SYNC_STAGES(2), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .bus(bus_if));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // register block: read data one clock after a read strobe
  always @(posedge clk) begin
    if (bus_if.valid === 1'b1 && bus_if.rw === 1'b0) bus_if.data_in_reg <= mem[bus_if.addr_to_reg];
  end

  always @(negedge clk) begin
    if (bus_if.valid === 1'b1) begin
      obs_q.push_back({bus_if.rw, bus_if.addr_to_reg, (bus_if.rw ? bus_if.data_to_reg : 8'h00)});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [12:0] e, o;
    check({tag, " strobe count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'h1FFF;
      check({tag, " strobe {rw,addr,data}"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic sclk_bit(input logic b, output logic mi, output logic oe, output int rc);
    spi_mosi = b;
    repeat (8) @(negedge clk);
    mi = spi_miso;
    oe = spi_miso_oe;
    spi_sclk = 1'b1;
    rc = cyc;
    repeat (8) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] wdata, input int ndata,
                       input bit end_cs, output logic [23:0] mv, output logic [23:0] ov);
    logic [23:0] bits;
    logic mi, oe;
    int rc;
    bits = {cmd, wdata};
    mv = 24'h000000;
    ov = 24'h000000;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8 + ndata; i++) begin
      sclk_bit(bits[23-i], mi, oe, rc);
      if (i == 7) rise8_cyc = rc;
      mv = {mv[22:0], mi};
      ov = {ov[22:0], oe};
    end
    if (end_cs) begin
      repeat (8) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[1] = 8'h96; mem[2] = 8'h03; mem[14] = 8'h5A; mem[15] = 8'hC3;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("reset miso", 32'(spi_miso), 32'd0);
    check("reset oe", 32'(spi_miso_oe), 32'd0);
    check("reset valid", 32'(bus_if.valid), 32'd0);
    check("reset rw", 32'(bus_if.rw), 32'd0);
    check("reset addr", 32'(bus_if.addr_to_reg), 32'd0);
    check("reset data", 32'(bus_if.data_to_reg), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // 1: single write
    exp_q.push_back({1'b1, 4'h1, 8'hA5});
    frame(8'h01 | 8'h80, 16'hA500, 8, 1'b1, miso_v, oe_v);
    check_sb("t1 write");
    check("t1 oe", 32'(oe_v), 32'd0);
    check("t1 data hold", 32'(bus_if.data_to_reg), 32'hA5);

    // 2: single read
    exp_q.push_back({1'b0, 4'h2, 8'h00});
    frame(8'h02, 16'h0000, 8, 1'b1, miso_v, oe_v);
    check("t2 latency", (obs_cyc_q.size() > 0) ? 32'(obs_cyc_q[0] - rise8_cyc) : 32'hFFFFFFFF, 32'd3);
    check_sb("t2 read");
    check("t2 miso", 32'(miso_v[15:0]), 32'h0003);
    check("t2 oe", 32'(oe_v[15:0]), 32'h00FF);

    // 3: aborted write, then a clean one
    frame(8'h80, 16'hF000, 4, 1'b1, miso_v, oe_v);
    check_sb("t3 abort");
    check("t3 oe", 32'(spi_miso_oe), 32'd0);
    check("t3 state", 32'(dut.state_r), 32'(IDLE));
    exp_q.push_back({1'b1, 4'h0, 8'h3C});
    frame(8'h80, 16'h3C00, 8, 1'b1, miso_v, oe_v);
    check_sb("t3 write");

    // 4: reset in the middle of a read
    exp_q.push_back({1'b0, 4'h1, 8'h00});
    frame(8'h01, 16'h0000, 3, 1'b0, miso_v, oe_v);
    check("t4 oe before reset", 32'(spi_miso_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4 pins in reset", 32'({spi_miso, spi_miso_oe}), 32'd0);
    check("t4 bus in reset", 32'({bus_if.valid, bus_if.rw, bus_if.addr_to_reg, bus_if.data_to_reg}), 32'd0);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_sb("t4 pre-reset");
    exp_q.push_back({1'b0, 4'h1, 8'h00});
    frame(8'h01, 16'h0000, 8, 1'b1, miso_v, oe_v);
    check_sb("t4 read");
    check("t4 miso", 32'(miso_v[7:0]), 32'h96);

    // 5: two-byte write frame
    exp_q.push_back({1'b1, 4'hF, 8'h11});
`ifdef SPI_BURST_EN
    exp_q.push_back({1'b1, 4'h0, 8'h22});
`endif
    frame(8'h8F, 16'h1122, 16, 1'b1, miso_v, oe_v);
    check_sb("t5 write");

    // 6: two-byte read frame
    exp_q.push_back({1'b0, 4'hE, 8'h00});
`ifdef SPI_BURST_EN
    exp_q.push_back({1'b0, 4'hF, 8'h00});
    exp_q.push_back({1'b0, 4'h0, 8'h00});
`endif
    frame(8'h0E, 16'h0000, 16, 1'b1, miso_v, oe_v);
    check_sb("t6 read");
`ifdef SPI_BURST_EN
    check("t6 miso", 32'(miso_v), 32'h005AC3);
    check("t6 oe", 32'(oe_v), 32'h00FFFF);
`else
    check("t6 miso", 32'(miso_v), 32'h005A00);
    check("t6 oe", 32'(oe_v), 32'h00FF00);
`endif
    check("t6 oe after frame", 32'(spi_miso_oe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
